// File: rtl/mealy_seq_arbiter.sv
// Two-requester round-robin front end for a shared serial Mealy detector.
// A granted pattern is shifted out MSB first and the detector's outputs are collected into result.
module mealy_seq_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] pat0,
  input  logic [W-1:0] pat1,
  output logic [1:0]   gnt,
  output logic         fsm_in,
  input  logic         fsm_out,
  output logic         fsm_rst,
  output logic [W-1:0] result,
  output logic         done,
  output logic [1:0]   state_dbg
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sreg;
  logic [W-2:0]  cap;
  logic          last_gnt1;
  logic          pick1;

  // last_gnt1 = 1 means requester 1 owned the previous job, so requester 0 wins a tie.
  assign pick1     = req1 & (~req0 | ~last_gnt1);
  assign fsm_in    = (state == SHIFT) & sreg[W-1];
  assign state_dbg = state;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      done      <= 1'b0;
      result    <= '0;
      fsm_rst   <= 1'b1;
      cnt       <= '0;
      sreg      <= '0;
      cap       <= '0;
      last_gnt1 <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req0 | req1) begin
            state   <= SHIFT;
            fsm_rst <= 1'b0;
            cnt     <= '0;
            cap     <= '0;
            if (pick1) begin
              gnt  <= 2'b10;
              sreg <= pat1;
            end else begin
              gnt  <= 2'b01;
              sreg <= pat0;
            end
          end
        end
        SHIFT: begin
          sreg <= {sreg[W-2:0], 1'b0};
          cap  <= (W-1)'({cap, fsm_out});
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            state   <= DONE;
            result  <= {cap, fsm_out};
            done    <= 1'b1;
            fsm_rst <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          gnt       <= 2'b00;
          last_gnt1 <= gnt[1];
          sreg      <= '0;
        end
        default: begin
          state   <= IDLE;
          gnt     <= 2'b00;
          done    <= 1'b0;
          fsm_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mealy_seq_arbiter.sv
// Directed bench for mealy_seq_arbiter with a small behavioural Mealy detector attached.
// The detector counts consecutive ones from S0 and emits a fixed per-count bit on each 1 input.
module tb_mealy_seq_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] pat0, pat1;
  logic [1:0]   gnt;
  logic         fsm_in, fsm_out, fsm_rst;
  logic [W-1:0] result;
  logic         done;
  logic [1:0]   state_dbg;

  int checks;
  int errors;

  mealy_seq_arbiter #(.W(W)) dut (
    .clk       (clk),
    .Reset     (rst),
    .req0      (req0),
    .req1      (req1),
    .pat0      (pat0),
    .pat1      (pat1),
    .gnt       (gnt),
    .fsm_in    (fsm_in),
    .fsm_out   (fsm_out),
    .fsm_rst   (fsm_rst),
    .result    (result),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // detector: out = in & tab[7 - ones_seen]; a 0 input returns it to S0
  logic [2:0] det_st;
  logic [7:0] det_tab;
  assign det_tab = 8'b1110_1101;
  assign fsm_out = fsm_in & det_tab[3'd7 - det_st];

  always @(posedge clk) begin
    if (fsm_rst) det_st <= 3'd0;
    else if (fsm_in) det_st <= det_st + 3'd1;
    else det_st <= 3'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; runs one complete job from a sole requester.
  task automatic do_job(input bit rq, input logic [7:0] pat, input bit flip,
                        input logic [1:0] eg, input logic [7:0] er);
    if (rq) begin
      pat1 = pat; req1 = 1'b1; req0 = 1'b0;
    end else begin
      pat0 = pat; req0 = 1'b1; req1 = 1'b0;
    end
    @(negedge clk);
    check("grant", gnt, eg);
    check("fsm_rst_shift0", fsm_rst, 1'b0);
    check("fsm_in_bit7", fsm_in, pat[7]);
    check("state_shift", state_dbg, 2'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (flip) begin
      pat0 = ~pat;
      pat1 = ~pat;
    end
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check("fsm_in_bit", fsm_in, pat[7-k]);
      check("fsm_rst_shift", fsm_rst, 1'b0);
      check("done_early", done, 1'b0);
      check("gnt_hold", gnt, eg);
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("result", result, er);
    check("gnt_in_done", gnt, eg);
    check("fsm_rst_done", fsm_rst, 1'b1);
    check("fsm_in_done", fsm_in, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("gnt_idle", gnt, 2'b00);
    check("result_hold", result, er);
    check("fsm_rst_idle", fsm_rst, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    pat0 = '0;
    pat1 = '0;

    @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_fsm_in", fsm_in, 1'b0);
    check("rst_fsm_rst", fsm_rst, 1'b1);
    check("rst_state", state_dbg, 2'd0);
    rst = 1'b0;

    do_job(1'b0, 8'hF0, 1'b0, 2'b01, 8'hE0);
    do_job(1'b1, 8'hFF, 1'b0, 2'b10, 8'hED);
    do_job(1'b0, 8'h00, 1'b0, 2'b01, 8'h00);
    // pattern changed and request dropped right after the grant edge
    do_job(1'b0, 8'hFF, 1'b1, 2'b01, 8'hED);

    // abort a job after its 4th shift edge
    pat0 = 8'hFF;
    req0 = 1'b1;
    @(negedge clk);
    check("abort_grant", gnt, 2'b01);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_gnt", gnt, 2'b00);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 8'h00);
    check("abort_fsm_rst", fsm_rst, 1'b1);
    check("abort_fsm_in", fsm_in, 1'b0);
    check("abort_state", state_dbg, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    do_job(1'b0, 8'hF0, 1'b0, 2'b01, 8'hE0);

    // both requesters held high from reset: grants alternate every 10 cycles
    rst  = 1'b1;
    pat0 = 8'hF0;
    pat1 = 8'hFF;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      logic [1:0] eg;
      logic [7:0] er;
      eg = (j % 2 == 0) ? 2'b01 : 2'b10;
      er = (j % 2 == 0) ? 8'hE0 : 8'hED;
      @(negedge clk);
      check("rr_grant", gnt, eg);
      check("rr_no_done", done, 1'b0);
      repeat (8) @(negedge clk);
      check("rr_done", done, 1'b1);
      check("rr_gnt_in_done", gnt, eg);
      check("rr_result", result, er);
      @(negedge clk);
      check("rr_done_low", done, 1'b0);
      check("rr_gnt_idle", gnt, 2'b00);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // gnt must never be two-hot
  always @(negedge clk) begin
    if (gnt == 2'b11) begin
      errors++;
      $error("FAIL gnt_onehot observed %b expected not 11", gnt);
    end
  end

endmodule
